// File: rtl/serial_cmd_host.sv
// serial_cmd_host: host-side initiator for the byte-serial memory command protocol.
// Serializes write/read/complete requests to a byte transmitter and collects the target's reply bytes.
module serial_cmd_host #(
  parameter int unsigned ADDR_WIDTH     = 24,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  req_rdy,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [7:0]            serial_data_out,
  output logic                  serial_out_en,
  input  logic                  serial_out_rdy,
  input  logic [7:0]            serial_data_in,
  input  logic                  serial_in_cplt,
  input  logic                  serial_in_error
);

  localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IDX_W    = 3;
  localparam logic [7:0]  ACK_BYTE = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_GAP, S_RX_ACK, S_RX_LO, S_RX_HI
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'd0,
    OP_READ    = 2'd1,
    OP_CPLT    = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_t;

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  rsp_valid_d, rsp_err_d, serial_out_en_d;
  logic [DATA_WIDTH-1:0] rsp_data_d;
  logic [7:0]            serial_data_out_d;

  logic [7:0]            cur_byte;
  logic [IDX_W-1:0]      n_bytes;
  logic                  tmo_hit;

  assign req_rdy = (state_q == S_IDLE);
  assign busy    = (state_q != S_IDLE);
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Protocol byte for the current position of the latched request
  always_comb begin
    cur_byte = 8'h02;
    n_bytes  = IDX_W'(1);
    case (op_q)
      OP_WRITE: begin
        n_bytes = IDX_W'(6);
        case (idx_q)
          3'd0:    cur_byte = 8'h00;
          3'd1:    cur_byte = addr_q[7:0];
          3'd2:    cur_byte = addr_q[15:8];
          3'd3:    cur_byte = addr_q[23:16];
          3'd4:    cur_byte = data_q[7:0];
          default: cur_byte = data_q[15:8];
        endcase
      end
      OP_READ: begin
        n_bytes = IDX_W'(4);
        case (idx_q)
          3'd0:    cur_byte = 8'h01;
          3'd1:    cur_byte = addr_q[7:0];
          3'd2:    cur_byte = addr_q[15:8];
          default: cur_byte = addr_q[23:16];
        endcase
      end
      default: begin
        cur_byte = 8'h02;
        n_bytes  = IDX_W'(1);
      end
    endcase
  end

  // Next-state and next-output decode
  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    addr_d            = addr_q;
    data_d            = data_q;
    idx_d             = idx_q;
    tmo_d             = tmo_q;
    rsp_valid_d       = 1'b0;
    rsp_err_d         = rsp_err;
    rsp_data_d        = rsp_data;
    serial_data_out_d = serial_data_out;
    serial_out_en_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = op_t'(req_op);
          addr_d = req_addr;
          data_d = req_data;
          idx_d  = '0;
          if (op_t'(req_op) == OP_ILLEGAL) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = S_SEND;
          end
        end
      end

      S_SEND: begin
        if (serial_out_rdy) begin
          serial_data_out_d = cur_byte;
          serial_out_en_d   = 1'b1;
          idx_d             = idx_q + IDX_W'(1);
          state_d           = S_GAP;
        end
      end

      S_GAP: begin
        if (idx_q != n_bytes) begin
          state_d = S_SEND;
        end else begin
          tmo_d = '0;
          case (op_q)
            OP_WRITE: state_d = S_RX_ACK;
            OP_READ:  state_d = S_RX_LO;
            default: begin
              state_d     = S_IDLE;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b0;
            end
          endcase
        end
      end

      S_RX_ACK, S_RX_LO, S_RX_HI: begin
        tmo_d = tmo_q + TMO_W'(1);
        // Receiver error wins over a coincident byte
        if (serial_in_error) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (serial_in_cplt) begin
          tmo_d = '0;
          case (state_q)
            S_RX_ACK: begin
              state_d     = S_IDLE;
              rsp_valid_d = 1'b1;
              rsp_err_d   = (serial_data_in != ACK_BYTE);
            end
            S_RX_LO: begin
              rsp_data_d[7:0] = serial_data_in;
              state_d         = S_RX_HI;
            end
            default: begin
              rsp_data_d[15:8] = serial_data_in;
              state_d          = S_IDLE;
              rsp_valid_d      = 1'b1;
              rsp_err_d        = 1'b0;
            end
          endcase
        end else if (tmo_hit) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      op_q            <= OP_WRITE;
      addr_q          <= '0;
      data_q          <= '0;
      idx_q           <= '0;
      tmo_q           <= '0;
      rsp_valid       <= 1'b0;
      rsp_err         <= 1'b0;
      rsp_data        <= '0;
      serial_data_out <= 8'h00;
      serial_out_en   <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      idx_q           <= idx_d;
      tmo_q           <= tmo_d;
      rsp_valid       <= rsp_valid_d;
      rsp_err         <= rsp_err_d;
      rsp_data        <= rsp_data_d;
      serial_data_out <= serial_data_out_d;
      serial_out_en   <= serial_out_en_d;
    end
  end

endmodule

// File: tb/tb_serial_cmd_host.sv
// tb_serial_cmd_host: directed table plus randomized transactions against a byte-level reference model.
// A passive monitor records transmitted bytes and watches the strobe/data protocol.
module tb_serial_cmd_host;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [23:0] req_addr;
  logic [15:0] req_data;
  logic        req_rdy;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [7:0]  serial_data_out;
  logic        serial_out_en;
  logic        serial_out_rdy;
  logic [7:0]  serial_data_in;
  logic        serial_in_cplt;
  logic        serial_in_error;

  serial_cmd_host #(
    .ADDR_WIDTH(24), .DATA_WIDTH(16), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .req_rdy(req_rdy), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .serial_data_out(serial_data_out), .serial_out_en(serial_out_en),
    .serial_out_rdy(serial_out_rdy), .serial_data_in(serial_data_in),
    .serial_in_cplt(serial_in_cplt), .serial_in_error(serial_in_error)
  );

  always #5 clk = ~clk;

  // scen: 0 normal reply, 1 error first, 2 error after low byte, 3 no reply
  typedef struct {
    logic [1:0]  op;
    logic [23:0] addr;
    logic [15:0] data;
    int          scen;
    logic [7:0]  b0;
    logic [7:0]  b1;
    bit          coincide;
    bit          stray;
    int          stall;
    logic [47:0] exp_tx;
    int          exp_n;
    logic        exp_err;
    logic [15:0] exp_data;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          proto_bad = 0;
  logic [7:0]  tx_q[$];
  logic        prev_en = 1'b0;
  logic [7:0]  last_b = 8'h00;
  logic [15:0] mdl_data;
  vec_t        tbl[10];

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 1'b0;
      last_b  = 8'h00;
    end else begin
      if (serial_out_en) begin
        if (prev_en) proto_bad++;
        tx_q.push_back(serial_data_out);
        last_b = serial_data_out;
      end else if (serial_data_out !== last_b) begin
        proto_bad++;
      end
      prev_en = serial_out_en;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [23:0] a, input logic [15:0] d,
                              input int scen, input logic [7:0] b0, input logic [7:0] b1,
                              input bit coincide, input bit stray, input int stall,
                              input logic [47:0] etx, input int en, input logic eerr,
                              input logic [15:0] edata);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.scen = scen; v.b0 = b0; v.b1 = b1;
    v.coincide = coincide; v.stray = stray; v.stall = stall;
    v.exp_tx = etx; v.exp_n = en; v.exp_err = eerr; v.exp_data = edata;
    return v;
  endfunction

  // Reference: protocol bytes and response derived arithmetically from the request
  function automatic vec_t model(input logic [1:0] op, input logic [23:0] a, input logic [15:0] d,
                                 input int scen, input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [15:0] cur);
    vec_t v;
    int   ai, di;
    int   bq[$];
    v = mk(op, a, d, scen, b0, b1, 1'b0, 1'b0, 0, 48'h0, 0, 1'b1, cur);
    ai = int'(a);
    di = int'(d);
    bq.delete();
    case (op)
      2'd0: bq = '{0, ai % 256, (ai / 256) % 256, ai / 65536, di % 256, di / 256};
      2'd1: bq = '{1, ai % 256, (ai / 256) % 256, ai / 65536};
      2'd2: bq = '{2};
      default: bq.delete();
    endcase
    v.exp_n = bq.size();
    foreach (bq[i]) v.exp_tx = v.exp_tx | (48'(bq[i]) << (8 * i));
    if (op == 2'd2) v.exp_err = 1'b0;
    else if (op == 2'd0 && scen == 0) v.exp_err = (b0 != 8'd69);
    else if (op == 2'd1 && scen == 0) begin
      v.exp_data = 16'(int'(b1) * 256 + int'(b0));
      v.exp_err  = 1'b0;
    end else if (op == 2'd1 && scen == 2) v.exp_data = 16'((int'(cur) / 256) * 256 + int'(b0));
    return v;
  endfunction

  task automatic pulse_in(input logic [7:0] b, input logic cplt, input logic err);
    serial_data_in  = b;
    serial_in_cplt  = cplt;
    serial_in_error = err;
    tick();
    serial_in_cplt  = 1'b0;
    serial_in_error = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int          guard;
    int          early;
    int          n;
    bit          stall_done;
    bit          stray_done;
    logic [63:0] got;
    guard = 0;
    while (!req_rdy && guard < 1000) begin tick(); guard++; end
    check({nm, ":rdy"}, 64'(req_rdy), 64'd1);
    tx_q.delete();
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_data = v.data;
    tick();
    req_valid = 1'b0; req_op = 2'($urandom); req_addr = 24'($urandom); req_data = 16'($urandom);
    if (v.op == 2'd3) begin
      check({nm, ":ill_valid"}, 64'(rsp_valid), 64'd1);
      check({nm, ":ill_err"}, 64'(rsp_err), 64'd1);
      check({nm, ":ill_data"}, 64'(rsp_data), 64'(v.exp_data));
      check({nm, ":ill_busy"}, 64'(busy), 64'd0);
      tick();
      check({nm, ":ill_nobytes"}, 64'(tx_q.size()), 64'd0);
      check({nm, ":pulse"}, 64'(rsp_valid), 64'd0);
      return;
    end
    check({nm, ":busy"}, 64'(busy), 64'd1);
    guard = 0; stall_done = 0; stray_done = 0;
    while (tx_q.size() < v.exp_n && guard < 2000) begin
      if (v.stall > 0 && tx_q.size() == 2 && !stall_done) begin
        serial_out_rdy = 1'b0;
        n = tx_q.size();
        repeat (v.stall) tick();
        check({nm, ":stall_hold"}, 64'(tx_q.size()), 64'(n));
        serial_out_rdy = 1'b1;
        stall_done = 1;
      end
      if (v.stray && tx_q.size() == 1 && !stray_done) begin
        stray_done = 1;
        pulse_in(8'h45, 1'b1, 1'b0);
      end else begin
        tick();
      end
      guard++;
    end
    got = '0;
    for (int i = 0; i < tx_q.size() && i < 8; i++) got[8*i +: 8] = tx_q[i];
    check({nm, ":bytes"}, got, {16'h0, v.exp_tx});
    if (v.op == 2'd2) begin
      tick();
    end else begin
      tick();
      case (v.scen)
        0: begin
          pulse_in(v.b0, 1'b1, 1'b0);
          if (v.op == 2'd1) begin
            repeat ($urandom_range(0, 3)) tick();
            pulse_in(v.b1, 1'b1, 1'b0);
          end
        end
        1: pulse_in(8'h45, v.coincide, 1'b1);
        2: begin
          pulse_in(v.b0, 1'b1, 1'b0);
          repeat ($urandom_range(0, 3)) tick();
          pulse_in(8'h00, v.coincide, 1'b1);
        end
        default: begin
          early = 0;
          for (int k = 2; k <= TMO; k++) begin
            tick();
            if (rsp_valid) early++;
          end
          check({nm, ":tmo_early"}, 64'(early), 64'd0);
          tick();
        end
      endcase
    end
    check({nm, ":valid"}, 64'(rsp_valid), 64'd1);
    check({nm, ":err"}, 64'(rsp_err), 64'(v.exp_err));
    check({nm, ":data"}, 64'(rsp_data), 64'(v.exp_data));
    tick();
    check({nm, ":pulse"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          guard;
    int          seen_rsp;
    int          r;
    int          sc;
    logic [1:0]  op;
    logic [7:0]  b0;
    vec_t        v;

    tbl[0] = mk(2'd0, 24'h123456, 16'hBEEF, 0, 8'h45, 8'h00, 0, 0, 0, 48'hBEEF12345600, 6, 1'b0, 16'h0000);
    tbl[1] = mk(2'd1, 24'h000010, 16'h0000, 0, 8'h34, 8'h12, 0, 0, 0, 48'h000000001001, 4, 1'b0, 16'h1234);
    tbl[2] = mk(2'd0, 24'hABCDEF, 16'h0102, 0, 8'h00, 8'h00, 0, 0, 0, 48'h0102ABCDEF00, 6, 1'b1, 16'h1234);
    tbl[3] = mk(2'd1, 24'h00A5A5, 16'h0000, 2, 8'h77, 8'h00, 0, 0, 0, 48'h0000_00A5A501, 4, 1'b1, 16'h1277);
    tbl[4] = mk(2'd1, 24'h000001, 16'h0000, 3, 8'h00, 8'h00, 0, 1, 0, 48'h000000000101, 4, 1'b1, 16'h1277);
    tbl[5] = mk(2'd0, 24'h00FF00, 16'h5AA5, 0, 8'h45, 8'h00, 0, 0, 50, 48'h5AA500FF0000, 6, 1'b0, 16'h1277);
    tbl[6] = mk(2'd2, 24'h000000, 16'h0000, 0, 8'h00, 8'h00, 0, 0, 0, 48'h000000000002, 1, 1'b0, 16'h1277);
    tbl[7] = mk(2'd3, 24'h000000, 16'h0000, 0, 8'h00, 8'h00, 0, 0, 0, 48'h000000000000, 0, 1'b1, 16'h1277);
    tbl[8] = mk(2'd1, 24'h7F0080, 16'h0000, 1, 8'h00, 8'h00, 1, 0, 0, 48'h00007F008001, 4, 1'b1, 16'h1277);
    tbl[9] = mk(2'd0, 24'h0A0B0C, 16'h0D0E, 0, 8'h45, 8'h00, 0, 0, 0, 48'h0D0E0A0B0C00, 6, 1'b0, 16'h0000);

    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_data = '0;
    serial_out_rdy = 1'b1; serial_data_in = 8'h00; serial_in_cplt = 1'b0; serial_in_error = 1'b0;
    repeat (3) tick();
    check("rst:rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst:rsp_err", 64'(rsp_err), 64'd0);
    check("rst:rsp_data", 64'(rsp_data), 64'd0);
    check("rst:out_en", 64'(serial_out_en), 64'd0);
    check("rst:data_out", 64'(serial_data_out), 64'd0);
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:req_rdy", 64'(req_rdy), 64'd1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while the third write byte is on the line
    tx_q.delete();
    req_valid = 1'b1; req_op = 2'd0; req_addr = 24'h111111; req_data = 16'h2222;
    tick();
    req_valid = 1'b0;
    guard = 0;
    while (tx_q.size() < 3 && guard < 100) begin tick(); guard++; end
    check("midrst:pre_bytes", 64'(tx_q.size()), 64'd3);
    rst_n = 1'b0;
    #1;
    check("midrst:out_en", 64'(serial_out_en), 64'd0);
    check("midrst:busy", 64'(busy), 64'd0);
    check("midrst:req_rdy", 64'(req_rdy), 64'd1);
    check("midrst:rsp_data", 64'(rsp_data), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    seen_rsp = 0;
    repeat (20) begin
      tick();
      if (rsp_valid) seen_rsp++;
    end
    check("midrst:no_rsp", 64'(seen_rsp), 64'd0);
    check("midrst:no_more_bytes", 64'(tx_q.size()), 64'd3);
    run_txn(tbl[9], "post_rst");

    mdl_data = 16'h0000;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 19);
      op = (r < 9) ? 2'd0 : (r < 18) ? 2'd1 : (r == 18) ? 2'd2 : 2'd3;
      r = $urandom_range(0, 19);
      sc = (r < 14) ? 0 : (r < 17) ? 1 : (r < 19) ? ((op == 2'd1) ? 2 : 1) : 3;
      b0 = (op == 2'd0 && $urandom_range(0, 1) == 1) ? 8'h45 : 8'($urandom);
      v = model(op, 24'($urandom), 16'($urandom), sc, b0, 8'($urandom), mdl_data);
      v.coincide = 1'($urandom_range(0, 1));
      v.stray    = ($urandom_range(0, 3) == 0);
      v.stall    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
      mdl_data   = v.exp_data;
      run_txn(v, $sformatf("rnd%0d", i));
    end

    check("protocol", 64'(proto_bad), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_cmd_host.md
# serial_cmd_host

Host-side initiator for the byte-serial memory command protocol used to load and inspect memory before the CPU is released. It accepts one parallel request at a time (write, read or complete-init), serializes it into protocol bytes on a serial transmitter, and collects the target's response bytes from a serial receiver. It sits between a loader/test controller and the UART TX/RX pair that faces the target's init block.

## Interface

- ADDR_WIDTH, 24, request address width; protocol carries exactly 3 address bytes, only 24 supported
- DATA_WIDTH, 16, request/response data width; protocol carries exactly 2 data bytes, only 16 supported
- TIMEOUT_CYCLES, 1000000, max idle cycles waiting for a response byte; counter width $clog2(TIMEOUT_CYCLES+1)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_op  in  2  0 write, 1 read, 2 complete-init, 3 illegal
- req_addr  in  ADDR_WIDTH  target address
- req_data  in  DATA_WIDTH  write data (ignored for other ops)
- req_rdy  out  1  high only in IDLE
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  DATA_WIDTH  read data; holds until next rsp_valid
- rsp_err  out  1  qualifies rsp_valid; 1 = failed
- busy  out  1  high in any state other than IDLE
- serial_data_out  out  8  byte to transmitter
- serial_out_en  out  1  one-cycle transmit strobe
- serial_out_rdy  in  1  transmitter idle
- serial_data_in  in  8  received byte
- serial_in_cplt  in  1  one-cycle strobe, serial_data_in valid
- serial_in_error  in  1  one-cycle receiver framing error strobe

## Operation

- States: IDLE, SEND, GAP, RX_ACK, RX_LO, RX_HI.
- IDLE: req_valid && req_rdy accepts; op/addr/data latched; byte index cleared; op 3 → no bytes sent, rsp_valid with rsp_err=1, stay IDLE; else → SEND.
- Byte sequences: write = 0x00, addr[7:0], addr[15:8], addr[23:16], data[7:0], data[15:8]; read = 0x01, addr[7:0], addr[15:8], addr[23:16]; complete = 0x02.
- SEND: when serial_out_rdy=1, drive serial_data_out = current byte, pulse serial_out_en, increment index, → GAP. While serial_out_rdy=0, wait indefinitely (no timeout).
- GAP: serial_out_en low for one cycle; then, if more bytes remain → SEND; else write → RX_ACK, read → RX_LO, complete → IDLE with rsp_valid, rsp_err=0.
- RX_ACK: on serial_in_cplt, byte 0x45 (69) → rsp_err=0, else rsp_err=1; → IDLE with rsp_valid.
- RX_LO: on serial_in_cplt capture rsp_data[7:0] → RX_HI. RX_HI: capture rsp_data[15:8], rsp_err=0, → IDLE with rsp_valid.
- In RX_*: serial_in_error → rsp_valid, rsp_err=1, → IDLE; error takes priority over a simultaneous cplt.
- Timeout counter cleared on entering any RX_* state and on each serial_in_cplt; reaching TIMEOUT_CYCLES → rsp_valid, rsp_err=1, → IDLE; rsp_data unchanged except bytes already captured.
- serial_in_cplt/serial_in_error in IDLE, SEND or GAP are discarded.

## Timing

- Reset values: rsp_valid 0, rsp_err 0, rsp_data 0, serial_out_en 0, serial_data_out 0x00, busy 0, state IDLE (req_rdy 1).
- All outputs registered except req_rdy and busy (decoded from state).
- First serial_out_en no earlier than 1 cycle after acceptance; consecutive strobes at least 2 cycles apart (SEND+GAP).
- serial_out_en never high on two consecutive cycles; serial_data_out stable during and after the strobe until next strobe.
- rsp_valid asserts on the same edge state returns to IDLE; req_rdy high that cycle, so a back-to-back request can be accepted in the rsp_valid cycle.
- Minimum write latency with rdy stuck high: acceptance + 12 cycles for bytes, + ack arrival + 1.
- Reset mid-operation: immediate return to IDLE, serial_out_en forced 0, no rsp_valid.

## Test plan

- Write op=0 addr=0x123456 data=0xBEEF, rdy=1 → bytes 00,56,34,12,EF,BE each on a 1-cycle en separated by ≥1 low cycle; inject 0x45 → rsp_valid, rsp_err=0.
- Read op=1 addr=0x000010, respond 0x34 then 0x12 → bytes 01,10,00,00; rsp_valid, rsp_data=0x1234, rsp_err=0.
- Write with ack byte 0x00 → rsp_err=1; read with serial_in_error after first byte → rsp_err=1, rsp_data[15:8] unchanged.
- Read with no response, TIMEOUT_CYCLES=100 → rsp_valid, rsp_err=1 exactly 100 cycles after entering RX_LO; stray cplt during SEND ignored.
- serial_out_rdy held 0 for 50 cycles mid-write → no strobe until rdy=1, byte order intact; complete op=2 → single byte 02, rsp_valid rsp_err=0, no RX wait.
- op=3 → no serial_out_en, rsp_valid rsp_err=1 next cycle; rst_n pulsed during write byte 3 → en 0, IDLE, no rsp_valid, next request sent correctly.
